// File: rtl/clk_freq_monitor.sv
// ---------------------------------------------------------------------------
// clk_freq_monitor
//
// Measures the frequency of an asynchronous clock (CLK_MEAS) from the
// CLK_100 reference domain. It counts CLK_MEAS rising edges over a fixed
// gate window of GATE_CYCLES reference cycles, then reports the count. It
// also flags whether the count lies inside [EXP_MIN, EXP_MAX] and whether
// the monitored clock has stopped (count of zero).
//
// Parameters
//   GATE_CYCLES : gate window length in CLK_100 cycles (>= 4)
//   CNT_W       : width of the edge counter and FREQ_COUNT
//   EXP_MIN     : lowest in-range count
//   EXP_MAX     : highest in-range count
//
// Ports
//   CLK_100    in   reference clock, all logic runs on it
//   RST        in   asynchronous active-high reset
//   EN         in   run continuous measurements while high
//   CLK_MEAS   in   monitored clock (asynchronous, <= 40 MHz)
//   FREQ_COUNT out  edge count of the last completed window
//   VALID      out  one-cycle pulse when FREQ_COUNT/IN_RANGE/LOST update
//   IN_RANGE   out  EXP_MIN <= last count <= EXP_MAX
//   LOST       out  last count == 0
//   BUSY       out  high whenever the FSM is not idle
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | counters held at zero, waiting for EN
// ARM    | 3 cycles letting the synchronizer flush; edges ignored
// MEAS   | gate window open; gate_cnt runs, edge strobes are counted
// REPORT | one cycle; results just loaded, VALID high; edges ignored
// ---------------------------------------------------------------------------
module clk_freq_monitor #(
    parameter int GATE_CYCLES = 100000,
    parameter int CNT_W       = 20,
    parameter int EXP_MIN     = 24750,
    parameter int EXP_MAX     = 25250
) (
    input  logic             CLK_100,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLK_MEAS,
    output logic [CNT_W-1:0] FREQ_COUNT,
    output logic             VALID,
    output logic             IN_RANGE,
    output logic             LOST,
    output logic             BUSY
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LIMIT_LO  = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  LIMIT_HI  = CNT_W'(EXP_MAX);
    localparam logic [1:0]        ARM_LAST  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        MEAS   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        arm_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;

    logic              s1;
    logic              s2;
    logic              s3;
    logic              edge_stb;
    logic [CNT_W-1:0]  count_next;

    // -----------------------------------------------------------------------
    // Synchronizer: s1/s2 resolve metastability, s3 delays s2 by one cycle
    // so a rising edge of CLK_MEAS appears as a single-cycle strobe.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= CLK_MEAS;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_stb = s2 & ~s3;

    // Edge count including this cycle's strobe; sticks at all-ones so an
    // over-range clock never wraps to a small, plausible-looking value.
    always_comb begin
        count_next = edge_cnt;
        if (edge_stb && (edge_cnt != CNT_MAX)) begin
            count_next = edge_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs. Results are loaded on the edge
    // that enters REPORT, so they are visible during the REPORT cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            arm_cnt    <= 2'd0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            FREQ_COUNT <= '0;
            VALID      <= 1'b0;
            IN_RANGE   <= 1'b0;
            LOST       <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                IDLE: begin
                    arm_cnt  <= 2'd0;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    if (EN) begin
                        state <= ARM;
                        BUSY  <= 1'b1;
                    end else begin
                        BUSY  <= 1'b0;
                    end
                end

                ARM: begin
                    if (!EN) begin
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                        arm_cnt <= 2'd0;
                    end else if (arm_cnt == ARM_LAST) begin
                        state    <= MEAS;
                        arm_cnt  <= 2'd0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        arm_cnt <= arm_cnt + 2'd1;
                    end
                end

                MEAS: begin
                    if (!EN) begin
                        // Abort: the partial window is dropped and the
                        // previous results are left untouched.
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else if (gate_cnt == GATE_LAST) begin
                        state      <= REPORT;
                        edge_cnt   <= count_next;
                        FREQ_COUNT <= count_next;
                        IN_RANGE   <= (count_next >= LIMIT_LO) &&
                                      (count_next <= LIMIT_HI);
                        LOST       <= (count_next == '0);
                        VALID      <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        edge_cnt <= count_next;
                    end
                end

                REPORT: begin
                    // The report always completes; EN only decides
                    // whether another window follows.
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    if (EN) begin
                        state <= MEAS;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
`timescale 1ns/1ps
module tb_clk_freq_monitor;

    localparam int GATE    = 1000;
    localparam int EMIN    = 245;
    localparam int EMAX    = 255;
    localparam int SAT_MAX = 127;
    localparam int BUDGET  = GATE + 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clk_meas = 1'b0;
    logic [11:0] freq_count;
    logic        valid, in_range, lost, busy;
    logic [6:0]  s_freq;
    logic        s_valid, s_in_range, s_lost, s_busy;

    int n_cmp = 0;
    int n_bad = 0;

    int meas_half_ps = 20000;
    bit meas_run     = 1'b1;

    clk_freq_monitor #(.GATE_CYCLES(GATE), .CNT_W(12), .EXP_MIN(EMIN), .EXP_MAX(EMAX)) dut (
        .CLK_100(clk), .RST(rst), .EN(en), .CLK_MEAS(clk_meas),
        .FREQ_COUNT(freq_count), .VALID(valid), .IN_RANGE(in_range),
        .LOST(lost), .BUSY(busy));

    // Narrow-counter instance sharing the same stimulus, for saturation.
    clk_freq_monitor #(.GATE_CYCLES(GATE), .CNT_W(7), .EXP_MIN(100), .EXP_MAX(120)) dut_sat (
        .CLK_100(clk), .RST(rst), .EN(en), .CLK_MEAS(clk_meas),
        .FREQ_COUNT(s_freq), .VALID(s_valid), .IN_RANGE(s_in_range),
        .LOST(s_lost), .BUSY(s_busy));

    always #5 clk = ~clk;

    always begin
        if (meas_run) begin
            #(meas_half_ps / 1000.0) clk_meas = 1'b1;
            #(meas_half_ps / 1000.0) clk_meas = 1'b0;
        end else begin
            clk_meas = 1'b0;
            #1;
        end
    end

    typedef struct {
        int half_ps;
        bit run;
        int lo;
        int hi;
        int exp_in;   // -1: decided from the reported count
        bit exp_lost;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input longint got, input longint lo, input longint hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Counts posedges from the current point until VALID is seen high.
    task automatic wait_valid(input string name, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= BUDGET && !seen; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    // EN goes high at a negedge; returns 1 ns after the edge that samples it.
    task automatic start_en();
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        check("busy_rise", busy, 1);
    endtask

    task automatic stop_en();
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        check("busy_fall", busy, 0);
    endtask

    task automatic check_window(input string tag, input int lo, input int hi, input int exp_in, input bit exp_lost);
        int ein;
        ein = exp_in;
        if (ein < 0) ein = (freq_count >= EMIN && freq_count <= EMAX) ? 1 : 0;
        check_range({tag, "_count"}, freq_count, lo, hi);
        check({tag, "_in_range"}, in_range, ein);
        check({tag, "_lost"}, lost, exp_lost);
        check({tag, "_sat_valid"}, s_valid, 1);
        check_range({tag, "_sat_count"}, s_freq, (lo > SAT_MAX) ? SAT_MAX : lo, (hi > SAT_MAX) ? SAT_MAX : hi);
        check({tag, "_sat_lost"}, s_lost, exp_lost);
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid) n++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int nv;
        int lo, hi, ein, period;
        string tag;

        // Reference model for a steady clock of period T: a window of
        // GATE*10 ns holds floor(L/T) or ceil(L/T) rising edges.
        vecs[0] = '{20000, 1'b1, 249, 251, 1, 1'b0};   // 25 MHz
        vecs[1] = '{25000, 1'b1, 199, 201, 0, 1'b0};   // 20 MHz
        vecs[2] = '{20000, 1'b0,   0,   0, 0, 1'b1};   // stopped
        vecs[3] = '{19900, 1'b1, 251, 252, 1, 1'b0};   // restart ~25.1 MHz
        vecs[4] = '{16000, 1'b1, 312, 313, 0, 1'b0};   // 31.25 MHz

        #12;
        check("rst_freq", freq_count, 0);
        check("rst_valid", valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_lost", lost, 0);
        check("rst_busy", busy, 0);
        #3.3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("idle_busy", busy, 0);

        // Table-driven windows: first-window latency, result, then the
        // back-to-back period and a second result.
        foreach (vecs[k]) begin
            tag = $sformatf("vec%0d", k);
            meas_half_ps = vecs[k].half_ps;
            meas_run     = vecs[k].run;
            repeat (30) @(posedge clk);
            start_en();
            wait_valid({tag, "_first"}, lat);
            check({tag, "_first_lat"}, lat + 1, GATE + 4);
            check_window({tag, "_w1"}, vecs[k].lo, vecs[k].hi, vecs[k].exp_in, vecs[k].exp_lost);
            wait_valid({tag, "_second"}, lat);
            check({tag, "_period"}, lat, GATE + 1);
            check_window({tag, "_w2"}, vecs[k].lo, vecs[k].hi, vecs[k].exp_in, vecs[k].exp_lost);
            if (k < 4) stop_en();
        end

        // Abort at gate_cnt == 500 (clock still 31.25 MHz, EN still high).
        stop_en();
        start_en();
        repeat (503) @(posedge clk);
        stop_en();
        count_valids(1100, nv);
        check("abort_no_valid", nv, 0);
        check_range("abort_keep_count", freq_count, 312, 313);
        check("abort_keep_lost", lost, 0);
        start_en();
        wait_valid("reen", lat);
        check("reen_lat", lat + 1, GATE + 4);
        check_window("reen", 312, 313, 0, 1'b0);

        // Asynchronous reset at gate_cnt == 700 of the following window.
        repeat (701) @(posedge clk);
        #3.7 rst = 1'b1;
        #0.4;
        check("mrst_freq", freq_count, 0);
        check("mrst_valid", valid, 0);
        check("mrst_in_range", in_range, 0);
        check("mrst_lost", lost, 0);
        check("mrst_busy", busy, 0);
        check("mrst_sat_freq", s_freq, 0);
        en = 1'b0;
        #21.3 rst = 1'b0;
        count_valids(1100, nv);
        check("mrst_no_valid", nv, 0);
        check("mrst_idle_busy", busy, 0);
        start_en();
        wait_valid("mrst_fresh", lat);
        check("mrst_fresh_lat", lat + 1, GATE + 4);
        check_window("mrst_fresh", 312, 313, 0, 1'b0);
        stop_en();

        // Randomized frequencies (<= ~40 MHz) and random abort points.
        for (int r = 0; r < 6; r++) begin
            tag          = $sformatf("rnd%0d", r);
            meas_half_ps = $urandom_range(12600, 60000);
            meas_run     = 1'b1;
            period       = 2 * meas_half_ps;
            lo           = (GATE * 10000) / period;
            hi           = (GATE * 10000 + period - 1) / period;
            if (lo >= EMIN && hi <= EMAX)   ein = 1;
            else if (hi < EMIN || lo > EMAX) ein = 0;
            else                            ein = -1;
            repeat (30) @(posedge clk);
            start_en();
            wait_valid(tag, lat);
            check({tag, "_lat"}, lat + 1, GATE + 4);
            check_window(tag, lo, hi, ein, 1'b0);
            repeat ($urandom_range(1, 900)) @(posedge clk);
            stop_en();
            count_valids(20, nv);
            check({tag, "_abort_no_valid"}, nv, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
